sub_serial: RTL and testbench

- Bit-serial subtractor. Computes diff = ina - inb - borrow_in over WIDTH clock cycles, LSB first, using one full-subtractor cell and shift registers.
- It is the inverse-operation companion to the team's combinational adder.
- Used in the datapath where area matters more than latency.
- Operands enter and the result leaves through valid/ready handshakes.

---
 rtl/sub_serial.sv | 117 +++++++++++
 tb/tb_sub_serial.sv | 210 +++++++++++++++++++++
 2 files changed

// File: rtl/sub_serial.sv
// Bit-serial unsigned subtractor: one full-subtractor cell walks the operands
// LSB first over WIDTH edges, with valid/ready handshakes on both sides.
module sub_serial #(
   parameter int WIDTH = 4
) (
   input  logic             clk,
   input  logic             rst_n,
   input  logic             in_valid,
   output logic             in_ready,
   input  logic [WIDTH-1:0] ina,
   input  logic [WIDTH-1:0] inb,
   input  logic             borrow_in,
   output logic             out_valid,
   input  logic             out_ready,
   output logic [WIDTH-1:0] diff_out,
   output logic             borrow_out,
   output logic             busy
);

   localparam int CW = (WIDTH > 1) ? $clog2(WIDTH) : 1;

   typedef enum logic [1:0] {IDLE, SHIFT, DONE} state_t;

   state_t           state, state_nx;
   logic [WIDTH-1:0] a_sh, b_sh;
   logic             br;
   logic [CW-1:0]    cnt;

   logic             a, b, d, br_nx, last, accept;
   logic [WIDTH-1:0] diff_nx;

   // Full-subtractor cell on the current LSBs.
   assign a      = a_sh[0];
   assign b      = b_sh[0];
   assign d      = a ^ b ^ br;
   assign br_nx  = (~a & b) | (~(a ^ b) & br);
   assign last   = (cnt == CW'(WIDTH - 1));
   assign accept = (state == IDLE) && in_valid;

   // Partial result holds the WIDTH-1 bits already produced; the final
   // bit joins them on the last shift edge.
   generate
      if (WIDTH == 1) begin : g_w1
         assign diff_nx = d;
      end else begin : g_wn
         logic [WIDTH-2:0] res_sh;
         assign diff_nx = {d, res_sh};
         always_ff @(posedge clk or negedge rst_n) begin
            if (!rst_n)
               res_sh <= '0;
            else if (state == SHIFT)
               res_sh <= diff_nx[WIDTH-1:1];
         end
      end
   endgenerate

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n)
         state <= IDLE;
      else
         state <= state_nx;
   end

   always_comb begin
      state_nx = state;
      case (state)
         IDLE:    if (in_valid)  state_nx = SHIFT;
         SHIFT:   if (last)      state_nx = DONE;
         DONE:    if (out_ready) state_nx = IDLE;
         default:                state_nx = IDLE;
      endcase
   end

   always_comb begin
      in_ready  = 1'b0;
      out_valid = 1'b0;
      busy      = 1'b0;
      case (state)
         IDLE:    in_ready  = 1'b1;
         SHIFT:   busy      = 1'b1;
         DONE: begin
            out_valid = 1'b1;
            busy      = 1'b1;
         end
         default: ;
      endcase
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         a_sh       <= '0;
         b_sh       <= '0;
         br         <= 1'b0;
         cnt        <= '0;
         diff_out   <= '0;
         borrow_out <= 1'b0;
      end else if (accept) begin
         a_sh <= ina;
         b_sh <= inb;
         br   <= borrow_in;
         cnt  <= '0;
      end else if (state == SHIFT) begin
         a_sh <= a_sh >> 1;
         b_sh <= b_sh >> 1;
         br   <= br_nx;
         // Counter parks at zero on the final edge rather than wrapping.
         if (last) begin
            cnt        <= '0;
            diff_out   <= diff_nx;
            borrow_out <= br_nx;
         end else begin
            cnt <= cnt + CW'(1);
         end
      end
   end

endmodule

// File: tb/tb_sub_serial.sv
// Bench for sub_serial (WIDTH=4): directed vectors, backpressure, mid-op
// reset and a randomized-handshake sweep over every operand combination.
module tb_sub_serial;

   localparam int W = 4;

   logic         clk = 1'b0;
   logic         rst_n;
   logic         in_valid;
   logic         in_ready;
   logic [W-1:0] ina, inb;
   logic         borrow_in;
   logic         out_valid;
   logic         out_ready;
   logic [W-1:0] diff_out;
   logic         borrow_out;
   logic         busy;

   int checks = 0;
   int errors = 0;

   sub_serial #(.WIDTH(W)) dut (
      .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(in_ready),
      .ina(ina), .inb(inb), .borrow_in(borrow_in), .out_valid(out_valid),
      .out_ready(out_ready), .diff_out(diff_out), .borrow_out(borrow_out),
      .busy(busy)
   );

   always #5 clk = ~clk;

   // Reference: plain signed integer subtraction, then wrap to W bits.
   function automatic logic [W:0] ref_sub(input logic [W-1:0] a, input logic [W-1:0] b,
                                          input logic bi);
      int r;
      logic [W-1:0] dd;
      r  = int'(a) - int'(b) - int'(bi);
      dd = W'(r & ((1 << W) - 1));
      return {(r < 0), dd};
   endfunction

   task automatic test_reset();
      rst_n = 1'b0; in_valid = 1'b0; out_ready = 1'b0;
      ina = '0; inb = '0; borrow_in = 1'b0;
      #12;
      checks++;
      if ({in_ready, out_valid, busy, diff_out, borrow_out} !== {3'b100, 4'h0, 1'b0}) begin
         errors++;
         $display("FAIL reset: rdy/vld/busy/diff/bo=%b%b%b/%h/%b required 100/0/0",
                  in_ready, out_valid, busy, diff_out, borrow_out);
      end
      @(posedge clk); #1 rst_n = 1'b1;
   endtask

   task automatic test_directed();
      logic [W-1:0] ta [6] = '{4'd9, 4'd3, 4'd0, 4'hF, 4'hF, 4'd7};
      logic [W-1:0] tb [6] = '{4'd3, 4'd9, 4'd0, 4'hF, 4'h0, 4'd7};
      logic         tc [6] = '{1'b0, 1'b0, 1'b1, 1'b1, 1'b0, 1'b0};
      logic [W:0]   exp;
      int           lat;
      for (int i = 0; i < 6; i++) begin
         exp = ref_sub(ta[i], tb[i], tc[i]);
         ina = ta[i]; inb = tb[i]; borrow_in = tc[i];
         in_valid = 1'b1; out_ready = 1'b1;
         @(posedge clk); #1 in_valid = 1'b0;
         lat = 0;
         while (!out_valid && lat < 20) begin
            @(posedge clk); #1 lat++;
         end
         checks++;
         if (lat !== W) begin
            errors++;
            $display("FAIL latency[%0d]: got %0d edges required %0d", i, lat, W);
         end
         checks++;
         if ({borrow_out, diff_out} !== exp) begin
            errors++;
            $display("FAIL result[%0d] %h-%h-%b: got bo=%b diff=%h required bo=%b diff=%h",
                     i, ta[i], tb[i], tc[i], borrow_out, diff_out, exp[W], exp[W-1:0]);
         end
         @(posedge clk); #1;
         checks++;
         if ({in_ready, out_valid, busy} !== 3'b100) begin
            errors++;
            $display("FAIL drain[%0d]: rdy/vld/busy=%b%b%b required 100",
                     i, in_ready, out_valid, busy);
         end
      end
   endtask

   task automatic test_backpressure();
      logic [W:0] exp;
      int         lat;
      exp = ref_sub(4'd12, 4'd5, 1'b1);
      ina = 4'd12; inb = 4'd5; borrow_in = 1'b1;
      in_valid = 1'b1; out_ready = 1'b0;
      @(posedge clk); #1 in_valid = 1'b0;
      lat = 0;
      while (!out_valid && lat < 20) begin
         @(posedge clk); #1 lat++;
      end
      for (int c = 0; c < 10; c++) begin
         in_valid = c[0]; ina = 4'($urandom); inb = 4'($urandom); borrow_in = 1'($urandom);
         @(posedge clk); #1;
         checks++;
         if ({out_valid, in_ready, borrow_out, diff_out} !== {2'b10, exp}) begin
            errors++;
            $display("FAIL hold[%0d]: vld/rdy=%b%b bo=%b diff=%h required 10 bo=%b diff=%h",
                     c, out_valid, in_ready, borrow_out, diff_out, exp[W], exp[W-1:0]);
         end
      end
      in_valid = 1'b0; out_ready = 1'b1;
      @(posedge clk); #1;
      checks++;
      if ({in_ready, out_valid, busy} !== 3'b100) begin
         errors++;
         $display("FAIL bp_drain: rdy/vld/busy=%b%b%b required 100", in_ready, out_valid, busy);
      end
   endtask

   task automatic test_reset_mid();
      logic [W:0] exp;
      int         lat;
      ina = 4'd14; inb = 4'd1; borrow_in = 1'b0; in_valid = 1'b1; out_ready = 1'b1;
      @(posedge clk); #1 in_valid = 1'b0;
      @(posedge clk); @(posedge clk); #2 rst_n = 1'b0;
      #1;
      checks++;
      if ({in_ready, out_valid, busy, diff_out, borrow_out} !== {3'b100, 4'h0, 1'b0}) begin
         errors++;
         $display("FAIL mid_reset: rdy/vld/busy/diff/bo=%b%b%b/%h/%b required 100/0/0",
                  in_ready, out_valid, busy, diff_out, borrow_out);
      end
      @(posedge clk); #1 rst_n = 1'b1;
      exp = ref_sub(4'd5, 4'd2, 1'b0);
      ina = 4'd5; inb = 4'd2; in_valid = 1'b1;
      @(posedge clk); #1 in_valid = 1'b0;
      lat = 0;
      while (!out_valid && lat < 20) begin
         @(posedge clk); #1 lat++;
      end
      checks++;
      if (lat !== W || {borrow_out, diff_out} !== exp) begin
         errors++;
         $display("FAIL post_reset_op: lat=%0d bo=%b diff=%h required lat=%0d bo=%b diff=%h",
                  lat, borrow_out, diff_out, W, exp[W], exp[W-1:0]);
      end
      @(posedge clk); #1;
   endtask

   task automatic test_back_to_back();
      logic [W:0] expq[$];
      logic [W:0] e;
      logic [8:0] v;
      int         sent = 0, got = 0;
      bit         acc, rel;
      v = 9'd0;
      {ina, inb, borrow_in} = v;
      in_valid = 1'b1; out_ready = 1'($urandom);
      for (int cyc = 0; cyc < 20000 && got < 512; cyc++) begin
         @(negedge clk);
         acc = in_ready && in_valid;
         rel = out_valid && out_ready;
         if (rel) begin
            checks++;
            if (expq.size() == 0) begin
               errors++;
               $display("FAIL b2b_extra: unexpected result bo=%b diff=%h", borrow_out, diff_out);
            end else begin
               e = expq.pop_front();
               if ({borrow_out, diff_out} !== e) begin
                  errors++;
                  $display("FAIL b2b[%0d]: got bo=%b diff=%h required bo=%b diff=%h",
                           got, borrow_out, diff_out, e[W], e[W-1:0]);
               end
            end
            got++;
         end
         if (acc) begin
            expq.push_back(ref_sub(ina, inb, borrow_in));
            sent++;
         end
         @(posedge clk); #1;
         if (sent < 512) begin
            v = 9'(sent);
            {ina, inb, borrow_in} = v;
         end else begin
            in_valid = 1'b0;
         end
         out_ready = 1'($urandom);
      end
      checks++;
      if (got !== 512 || sent !== 512 || expq.size() !== 0) begin
         errors++;
         $display("FAIL b2b_count: sent=%0d got=%0d pending=%0d required 512/512/0",
                  sent, got, expq.size());
      end
      out_ready = 1'b1;
   endtask

   initial begin
      test_reset();
      test_directed();
      test_backpressure();
      test_reset_mid();
      test_back_to_back();
      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule
